// File: rtl/object_extractor.sv
// Walks labeller entries 1..num_labels-1 after each frame, drops small objects and
// emits {id, area, centroid} records on a valid/ready stream via a bit-serial divider.
`ifndef LBL_WIDTH
`define LBL_WIDTH 8
`endif
`ifndef LOC_SIZE
`define LOC_SIZE 16
`endif

module object_extractor #(
   parameter int LBL_WIDTH  = `LBL_WIDTH,
   parameter int LOC_SIZE   = `LOC_SIZE,
   parameter int RD_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_done,
   input  logic [LBL_WIDTH-1:0] num_labels,
   input  logic [LOC_SIZE-1:0]  min_area,
   output logic [LBL_WIDTH-1:0] obj_id,
   input  logic [LOC_SIZE-1:0]  obj_area,
   input  logic [LOC_SIZE-1:0]  obj_x,
   input  logic [LOC_SIZE-1:0]  obj_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LBL_WIDTH-1:0] out_id,
   output logic [LOC_SIZE-1:0]  out_area,
   output logic [LOC_SIZE-1:0]  out_cx,
   output logic [LOC_SIZE-1:0]  out_cy,
   output logic                 busy,
   output logic                 done,
   output logic [LBL_WIDTH-1:0] obj_count
);

   localparam int CW = $clog2(LOC_SIZE);

   typedef enum logic [2:0] {IDLE, FETCH, DIV, OUT, NEXT, FINISH} state_t;
   state_t state;

   logic [LBL_WIDTH-1:0] n_lat;
   logic [1:0]           wait_cnt;
   logic [CW-1:0]        div_cnt;
   logic [LOC_SIZE-1:0]  area_r;
   logic [LOC_SIZE-1:0]  num_x, num_y;
   logic [LOC_SIZE:0]    rem_x, rem_y;

   logic [LOC_SIZE+1:0]  trial_x, trial_y;
   logic [LOC_SIZE:0]    rem_x_nxt, rem_y_nxt;
   logic [LOC_SIZE-1:0]  num_x_nxt, num_y_nxt;
   logic                 ge_x, ge_y;

   // One restoring step per cycle; the dividend register fills with quotient bits from the LSB.
   always_comb begin
      trial_x   = {rem_x, num_x[LOC_SIZE-1]};
      trial_y   = {rem_y, num_y[LOC_SIZE-1]};
      ge_x      = trial_x >= {2'b00, area_r};
      ge_y      = trial_y >= {2'b00, area_r};
      rem_x_nxt = ge_x ? (LOC_SIZE+1)'(trial_x - {2'b00, area_r}) : (LOC_SIZE+1)'(trial_x);
      rem_y_nxt = ge_y ? (LOC_SIZE+1)'(trial_y - {2'b00, area_r}) : (LOC_SIZE+1)'(trial_y);
      num_x_nxt = {num_x[LOC_SIZE-2:0], ge_x};
      num_y_nxt = {num_y[LOC_SIZE-2:0], ge_y};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         n_lat     <= '0;
         wait_cnt  <= '0;
         div_cnt   <= '0;
         area_r    <= '0;
         num_x     <= '0;
         num_y     <= '0;
         rem_x     <= '0;
         rem_y     <= '0;
         obj_id    <= '0;
         out_valid <= 1'b0;
         out_id    <= '0;
         out_area  <= '0;
         out_cx    <= '0;
         out_cy    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         obj_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_done) begin
                  n_lat     <= num_labels;
                  obj_id    <= LBL_WIDTH'(1);
                  obj_count <= '0;
                  wait_cnt  <= '0;
                  busy      <= 1'b1;
                  if (num_labels <= LBL_WIDTH'(1)) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            FETCH: begin
               // Read data is valid RD_LATENCY edges after obj_id moved.
               if (wait_cnt == 2'(RD_LATENCY)) begin
                  area_r  <= obj_area;
                  num_x   <= obj_x;
                  num_y   <= obj_y;
                  rem_x   <= '0;
                  rem_y   <= '0;
                  div_cnt <= '0;
                  if (obj_area == '0 || obj_area < min_area)
                     state <= NEXT;
                  else
                     state <= DIV;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            DIV: begin
               rem_x   <= rem_x_nxt;
               rem_y   <= rem_y_nxt;
               num_x   <= num_x_nxt;
               num_y   <= num_y_nxt;
               div_cnt <= div_cnt + CW'(1);
               if (div_cnt == CW'(LOC_SIZE-1)) begin
                  out_valid <= 1'b1;
                  out_id    <= obj_id;
                  out_area  <= area_r;
                  out_cx    <= num_x_nxt;
                  out_cy    <= num_y_nxt;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (obj_count != '1)
                     obj_count <= obj_count + LBL_WIDTH'(1);
                  state <= NEXT;
               end
            end
            NEXT: begin
               if (obj_id == n_lat - LBL_WIDTH'(1)) begin
                  state <= FINISH;
                  done  <= 1'b1;
               end else begin
                  obj_id   <= obj_id + LBL_WIDTH'(1);
                  wait_cnt <= '0;
                  state    <= FETCH;
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_object_extractor.sv
// Directed and randomized scans of object_extractor against a table-driven reference model.
module tb_object_extractor;

   localparam int LW = 8;
   localparam int LS = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_done;
   logic [LW-1:0] num_labels;
   logic [LS-1:0] min_area;
   logic [LW-1:0] obj_id;
   logic [LS-1:0] obj_area, obj_x, obj_y;
   logic          out_valid, out_ready;
   logic [LW-1:0] out_id;
   logic [LS-1:0] out_area, out_cx, out_cy;
   logic          busy, done;
   logic [LW-1:0] obj_count;

   object_extractor #(.LBL_WIDTH(LW), .LOC_SIZE(LS), .RD_LATENCY(1)) dut (
      .clk(clk), .reset(reset), .frame_done(frame_done), .num_labels(num_labels),
      .min_area(min_area), .obj_id(obj_id), .obj_area(obj_area), .obj_x(obj_x),
      .obj_y(obj_y), .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_area(out_area), .out_cx(out_cx), .out_cy(out_cy), .busy(busy),
      .done(done), .obj_count(obj_count)
   );

   always #5 clk = ~clk;

   typedef struct { int id; int area; int cx; int cy; } rec_t;
   rec_t exp_q[$];
   int   area_tab [256];
   int   x_tab [256];
   int   y_tab [256];
   int   n_assert = 0;
   int   n_fail = 0;
   int   rec_cnt = 0;

   // Labeller table with a one-cycle registered read.
   always @(posedge clk) begin
      obj_area <= LS'(area_tab[obj_id]);
      obj_x    <= LS'(x_tab[obj_id]);
      obj_y    <= LS'(y_tab[obj_id]);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      rec_t r;
      if (!reset && out_valid && out_ready) begin
         rec_cnt++;
         chk("record_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("out_id", 32'(out_id), r.id);
            chk("out_area", 32'(out_area), r.area);
            chk("out_cx", 32'(out_cx), r.cx);
            chk("out_cy", 32'(out_cy), r.cy);
         end
      end
   end

   // Reference: keep label if area nonzero and >= min; cost 20 cycles kept (ready high), 3 skipped.
   task automatic model_scan(input int n, input int mn, output int kept, output int lat, output int first);
      kept = 0; lat = 0; first = -1;
      for (int id = 1; id < n; id++) begin
         if (area_tab[id] != 0 && area_tab[id] >= mn) begin
            exp_q.push_back('{id, area_tab[id], x_tab[id] / area_tab[id], y_tab[id] / area_tab[id]});
            if (first < 0) first = lat + 2 + LS;
            lat += 2 + LS + 1 + 1;
            kept++;
         end else begin
            lat += 3;
         end
      end
   endtask

   task automatic start_scan(input int n, input int mn);
      num_labels = LW'(n);
      min_area   = LS'(mn);
      frame_done = 1'b1;
      @(posedge clk); #1;
      frame_done = 1'b0;
      chk("busy_at_e0", 32'(busy), 1);
      chk("id_at_e0", 32'(obj_id), 1);
   endtask

   task automatic run_scan(input int n, input int mn, input bit rand_rdy);
      int kept, lat, first, k, first_v;
      model_scan(n, mn, kept, lat, first);
      rec_cnt   = 0;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      start_scan(n, mn);
      k = 0; first_v = -1;
      while (!done && k < 5000) begin
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1; k++;
         if (out_valid && first_v < 0) first_v = k;
      end
      chk("done_seen", 32'(done), 1);
      if (!rand_rdy) begin
         chk("done_latency", k, lat);
         chk("first_valid", first_v, first);
      end
      chk("records", rec_cnt, kept);
      chk("obj_count", 32'(obj_count), kept);
      chk("queue_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 0);
      chk("busy_drop", 32'(busy), 0);
      chk("count_hold", 32'(obj_count), kept);
      out_ready = 1'b1;
   endtask

   initial begin
      int kept, lat, first, k, any_busy, n;
      for (int i = 0; i < 256; i++) begin area_tab[i] = 0; x_tab[i] = 0; y_tab[i] = 0; end
      reset = 1'b1; frame_done = 1'b0; num_labels = '0; min_area = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_obj_id", 32'(obj_id), 0);
      chk("rst_count", 32'(obj_count), 0);
      chk("rst_out_cx", 32'(out_cx), 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 0);

      // Single object
      area_tab[1] = 4; x_tab[1] = 42; y_tab[1] = 10;
      run_scan(2, 1, 1'b0);

      // Two skips then one kept
      area_tab[1] = 1; area_tab[2] = 0; area_tab[3] = 9; x_tab[3] = 90; y_tab[3] = 27;
      run_scan(4, 2, 1'b0);

      // Nothing to scan
      run_scan(1, 1, 1'b0);

      // Divider edge cases
      area_tab[1] = 1;     x_tab[1] = 65535; y_tab[1] = 0;
      area_tab[2] = 65535; x_tab[2] = 65534; y_tab[2] = 65535;
      area_tab[3] = 3;     x_tab[3] = 65535; y_tab[3] = 7;
      run_scan(4, 1, 1'b0);

      // Backpressure stall of 20 cycles
      area_tab[1] = 5; x_tab[1] = 100; y_tab[1] = 55;
      model_scan(2, 1, kept, lat, first);
      rec_cnt = 0; out_ready = 1'b0;
      start_scan(2, 1);
      k = 0;
      while (!out_valid && k < 200) begin @(posedge clk); #1; k++; end
      chk("bp_valid_seen", 32'(out_valid), 1);
      repeat (20) begin
         @(posedge clk); #1;
         chk("bp_valid_held", 32'(out_valid), 1);
         chk("bp_cx_held", 32'(out_cx), 20);
         chk("bp_cy_held", 32'(out_cy), 11);
         chk("bp_obj_id", 32'(obj_id), 1);
      end
      chk("bp_no_transfer", rec_cnt, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_valid_drop", 32'(out_valid), 0);
      chk("bp_one_transfer", rec_cnt, 1);
      k = 0;
      while (!done && k < 200) begin @(posedge clk); #1; k++; end
      chk("bp_done", 32'(done), 1);
      chk("bp_count", 32'(obj_count), 1);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Reset during DIV of id 2, with an ignored frame_done mid-scan
      area_tab[1] = 2; x_tab[1] = 10; y_tab[1] = 20;
      area_tab[2] = 3; x_tab[2] = 30; y_tab[2] = 31;
      exp_q.push_back('{1, 2, 5, 10});
      rec_cnt = 0;
      start_scan(3, 1);
      k = 0;
      while (obj_id != 2 && k < 200) begin
         frame_done = (k == 5);
         @(posedge clk); #1; k++;
      end
      frame_done = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_obj_id", 32'(obj_id), 0);
      chk("mid_rst_count", 32'(obj_count), 0);
      chk("mid_rst_out_id", 32'(out_id), 0);
      chk("mid_rst_records", rec_cnt, 1);
      chk("mid_rst_queue", exp_q.size(), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      any_busy = 0;
      repeat (30) begin @(posedge clk); #1; any_busy |= int'(busy); end
      chk("no_replay", any_busy, 0);
      run_scan(3, 1, 1'b0);

      // Randomized tables, alternating steady and random ready
      for (int s = 0; s < 8; s++) begin
         n = $urandom_range(0, 12);
         for (int id = 1; id < 13; id++) begin
            case ($urandom_range(0, 3))
               0:       area_tab[id] = 0;
               1:       area_tab[id] = $urandom_range(1, 5);
               default: area_tab[id] = $urandom_range(1, 65535);
            endcase
            x_tab[id] = $urandom_range(0, 65535);
            y_tab[id] = $urandom_range(0, 65535);
         end
         run_scan(n, $urandom_range(0, 6), (s % 2) == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
